// File: rtl/axis_lane_adder_pkg.sv
// Package axis_adder_pkg: shared constants and width helpers for the
// multi-lane AXI4-Stream adder.
//   MODE_PAIR / MODE_ACC : values for the MODE parameter
//   in_w()  : input tdata width  = lanes*2*width
//   out_w() : output tdata width = lanes*res_width
package axis_adder_pkg;

  localparam int unsigned MODE_PAIR = 0;
  localparam int unsigned MODE_ACC  = 1;

  function automatic int unsigned in_w(input int unsigned lanes, input int unsigned width);
    return lanes * 2 * width;
  endfunction

  function automatic int unsigned out_w(input int unsigned lanes, input int unsigned res_width);
    return lanes * res_width;
  endfunction

endpackage

// File: rtl/axis_lane_adder_if.sv
// AXI4-Stream bundle used for both sides of axis_lane_adder.
//   tdata  [DATA_W]  payload
//   tvalid / tready  handshake (transfer when both high)
//   tlast            end of frame
//   tuser  [USER_W]  sideband
// Modports: master drives payload/valid and samples ready; slave the reverse.
interface axis_lane_adder_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned USER_W = 1
);

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [USER_W-1:0] tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);

endinterface

// File: rtl/axis_lane_adder_lane.sv
// axis_adder_lane: one lane of the stream adder.
//   clk, rst   clock, synchronous active-high reset
//   accept_i   input beat accepted this cycle (accumulator update enable)
//   last_i     tlast of the accepted beat (restarts the running sum)
//   a_i, b_i   operands
//   res_o      combinational lane result, registered by the parent stage
//   clamp_o    result was clamped this cycle
// MODE_PAIR: res = a + b. MODE_ACC: res = acc + a + b, acc restarts after tlast.
// Macro AXIS_ADDER_SATURATE_EN: MODE_ACC sums clamp at all-ones instead of wrapping.
module axis_adder_lane
  import axis_adder_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned RES_WIDTH = 9,
  parameter int unsigned MODE      = MODE_PAIR
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 accept_i,
  input  logic                 last_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic [RES_WIDTH-1:0] res_o,
  output logic                 clamp_o
);

  logic [RES_WIDTH-1:0] acc_q;
  logic [RES_WIDTH-1:0] acc_d;
  logic [RES_WIDTH-1:0] acc_sel;

  assign acc_sel = (MODE == MODE_ACC) ? acc_q : '0;

`ifdef AXIS_ADDER_SATURATE_EN
  localparam int unsigned SUM_W = RES_WIDTH + 1;
  // One extra bit is enough: acc <= 2^R-1 and a+b <= 2^(W+1)-2 <= 2^R-2.
  logic [RES_WIDTH:0] wide_sum;

  always_comb begin
    wide_sum = {1'b0, acc_sel} + SUM_W'(a_i) + SUM_W'(b_i);
    clamp_o  = (MODE == MODE_ACC) && wide_sum[RES_WIDTH];
    res_o    = clamp_o ? '1 : wide_sum[RES_WIDTH-1:0];
  end
`else
  always_comb begin
    res_o   = acc_sel + RES_WIDTH'(a_i) + RES_WIDTH'(b_i);
    clamp_o = 1'b0;
  end
`endif

  // Only accepted beats move the accumulator, so output stalls never re-add.
  always_comb begin
    acc_d = acc_q;
    if (accept_i) begin
      acc_d = last_i ? '0 : res_o;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/axis_lane_adder.sv
// axis_lane_adder: multi-lane AXI4-Stream adder, two register stages
// (S1 = add result, S2 = output register), 2-cycle latency, 1 beat/cycle.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   s_axis  (slave)     LANES operand pairs per beat, lane i A=[2iW +: W], B=[(2i+1)W +: W]
//   m_axis  (master)    LANES sums per beat, lane i at [i*RES_WIDTH +: RES_WIDTH]
//   status_beat_count   output beats transferred (wraps at 2^32)
//   status_saturated    sticky clamp flag, only live with AXIS_ADDER_SATURATE_EN
// Parameters: LANES, WIDTH, RES_WIDTH (>= WIDTH+1), MODE (MODE_PAIR/MODE_ACC), USER_WIDTH.
// Macro AXIS_ADDER_SATURATE_EN: MODE_ACC sums clamp instead of wrapping.
module axis_lane_adder
  import axis_adder_pkg::*;
#(
  parameter int unsigned LANES      = 4,
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned RES_WIDTH  = 9,
  parameter int unsigned MODE       = MODE_PAIR,
  parameter int unsigned USER_WIDTH = 1
) (
  input  logic        clk,
  input  logic        rst,
  axis_lane_adder_if.slave  s_axis,
  axis_lane_adder_if.master m_axis,
  output logic [31:0] status_beat_count,
  output logic        status_saturated
);

  localparam int unsigned OUT_W = out_w(LANES, RES_WIDTH);

  logic                  s1_valid_q;
  logic [OUT_W-1:0]      s1_data_q;
  logic                  s1_last_q;
  logic [USER_WIDTH-1:0] s1_user_q;
  logic [OUT_W-1:0]      s1_data_d;

  logic                  m_valid_q;
  logic [OUT_W-1:0]      m_data_q;
  logic                  m_last_q;
  logic [USER_WIDTH-1:0] m_user_q;

  logic [31:0]           count_q;
  logic                  sat_q;
  logic [LANES-1:0]      lane_clamp;

  logic                  s1_advance;
  logic                  accept;

  // S1 moves into S2 when S2 is empty or S2 is draining this cycle.
  assign s1_advance    = s1_valid_q && (!m_valid_q || m_axis.tready);
  assign s_axis.tready = !rst && (!s1_valid_q || s1_advance);
  assign accept        = s_axis.tvalid && s_axis.tready;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    axis_adder_lane #(
      .WIDTH     (WIDTH),
      .RES_WIDTH (RES_WIDTH),
      .MODE      (MODE)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .accept_i (accept),
      .last_i   (s_axis.tlast),
      .a_i      (s_axis.tdata[2*i*WIDTH +: WIDTH]),
      .b_i      (s_axis.tdata[(2*i+1)*WIDTH +: WIDTH]),
      .res_o    (s1_data_d[i*RES_WIDTH +: RES_WIDTH]),
      .clamp_o  (lane_clamp[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_last_q  <= 1'b0;
      s1_user_q  <= '0;
    end else if (accept) begin
      s1_valid_q <= 1'b1;
      s1_data_q  <= s1_data_d;
      s1_last_q  <= s_axis.tlast;
      s1_user_q  <= s_axis.tuser;
    end else if (s1_advance) begin
      s1_valid_q <= 1'b0;
    end
  end

  // Payload only reloads on s1_advance, so it holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      m_user_q  <= '0;
    end else if (s1_advance) begin
      m_valid_q <= 1'b1;
      m_data_q  <= s1_data_q;
      m_last_q  <= s1_last_q;
      m_user_q  <= s1_user_q;
    end else if (m_axis.tready) begin
      m_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (m_valid_q && m_axis.tready) begin
      count_q <= count_q + 32'd1;
    end
  end

  // Lane clamp outputs are constant 0 unless saturation is compiled in,
  // so this flag stays 0 in the default build.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_q <= 1'b0;
    end else if (accept && (|lane_clamp)) begin
      sat_q <= 1'b1;
    end
  end

  assign m_axis.tvalid     = m_valid_q;
  assign m_axis.tdata      = m_data_q;
  assign m_axis.tlast      = m_last_q;
  assign m_axis.tuser      = m_user_q;
  assign status_beat_count = count_q;

`ifdef AXIS_ADDER_SATURATE_EN
  assign status_saturated = sat_q;
`else
  assign status_saturated = sat_q;
`endif

endmodule

// File: tb/tb_axis_lane_adder.sv
module tb_axis_lane_adder;
  import axis_adder_pkg::*;

  localparam int unsigned LANES      = 4;
  localparam int unsigned WIDTH      = 8;
  localparam int unsigned RES_WIDTH  = 9;
  localparam int unsigned USER_WIDTH = 1;
  localparam int unsigned IN_W       = LANES * 2 * WIDTH;
  localparam int unsigned OUT_W      = LANES * RES_WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axis_lane_adder_if #(.DATA_W(IN_W),  .USER_W(USER_WIDTH)) p_s ();
  axis_lane_adder_if #(.DATA_W(OUT_W), .USER_W(USER_WIDTH)) p_m ();
  axis_lane_adder_if #(.DATA_W(IN_W),  .USER_W(USER_WIDTH)) a_s ();
  axis_lane_adder_if #(.DATA_W(OUT_W), .USER_W(USER_WIDTH)) a_m ();

  logic [31:0] p_cnt, a_cnt;
  logic        p_sat, a_sat;

  axis_lane_adder #(.LANES(LANES), .WIDTH(WIDTH), .RES_WIDTH(RES_WIDTH),
                    .MODE(MODE_PAIR), .USER_WIDTH(USER_WIDTH)) dut_p (
    .clk(clk), .rst(rst), .s_axis(p_s), .m_axis(p_m),
    .status_beat_count(p_cnt), .status_saturated(p_sat));

  axis_lane_adder #(.LANES(LANES), .WIDTH(WIDTH), .RES_WIDTH(RES_WIDTH),
                    .MODE(MODE_ACC), .USER_WIDTH(USER_WIDTH)) dut_a (
    .clk(clk), .rst(rst), .s_axis(a_s), .m_axis(a_m),
    .status_beat_count(a_cnt), .status_saturated(a_sat));

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [OUT_W-1:0]      d;
    logic                  l;
    logic [USER_WIDTH-1:0] u;
  } beat_t;

  beat_t mon_q[$];

  // Records every accumulate-DUT output transfer (sampled mid-low-phase).
  always @(negedge clk) begin
    #2;
    if (a_m.tvalid === 1'b1 && a_m.tready === 1'b1)
      mon_q.push_back('{d: a_m.tdata, l: a_m.tlast, u: a_m.tuser});
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [IN_W-1:0] in_beat(input int unsigned a0, b0, a1, b1,
                                               a2, b2, a3, b3);
    logic [IN_W-1:0] v;
    v = {8'(b3), 8'(a3), 8'(b2), 8'(a2), 8'(b1), 8'(a1), 8'(b0), 8'(a0)};
    return v;
  endfunction

  function automatic logic [OUT_W-1:0] out_beat(input int unsigned r0, r1, r2, r3);
    logic [OUT_W-1:0] v;
    v = {9'(r3), 9'(r2), 9'(r1), 9'(r0)};
    return v;
  endfunction

  function automatic logic [IN_W-1:0] bp_in(input int unsigned k);
    return in_beat(k*20, k+1, k*20+1, k+10, k*20+2, 100, 255, k*25);
  endfunction

  function automatic logic [OUT_W-1:0] bp_out(input int unsigned k);
    return out_beat(k*21+1, k*21+11, k*20+102, 255+k*25);
  endfunction

  task automatic a_send(input logic [IN_W-1:0] d, input logic l, input logic u);
    int unsigned tries;
    logic ok;
    a_s.tdata = d; a_s.tlast = l; a_s.tuser = u; a_s.tvalid = 1'b1;
    tries = 0;
    forever begin
      #1;
      ok = a_s.tready;
      @(negedge clk);
      if (ok) break;
      tries++;
      if (tries > 50) begin
        checks++; errors++;
        $display("FAIL a_send_timeout: tready stayed %b, required 1", a_s.tready);
        break;
      end
    end
    a_s.tvalid = 1'b0;
  endtask

  task automatic wait_mon(input int unsigned n);
    for (int k = 0; k < 30; k++) begin
      if (mon_q.size() >= n) break;
      @(negedge clk);
    end
    #1;
    checks++;
    if (mon_q.size() != n) begin
      errors++;
      $display("FAIL out_beats: got %0d beats, required %0d", mon_q.size(), n);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (p_m.tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b required 0", p_m.tvalid); end
    checks++; if (p_m.tdata !== '0) begin errors++; $display("FAIL rst_tdata: got %h required 0", p_m.tdata); end
    checks++; if (p_m.tlast !== 1'b0 || p_m.tuser !== '0) begin errors++; $display("FAIL rst_side: got %b/%b required 0/0", p_m.tlast, p_m.tuser); end
    checks++; if (p_cnt !== 32'd0) begin errors++; $display("FAIL rst_count: got %0d required 0", p_cnt); end
    checks++; if (p_s.tready !== 1'b0) begin errors++; $display("FAIL rst_tready: got %b required 0", p_s.tready); end
    checks++; if (p_sat !== 1'b0 || a_sat !== 1'b0) begin errors++; $display("FAIL rst_sat: got %b/%b required 0/0", p_sat, a_sat); end
    checks++; if (a_m.tvalid !== 1'b0) begin errors++; $display("FAIL rst_acc_tvalid: got %b required 0", a_m.tvalid); end
    rst = 1'b0;
    #1;
    checks++; if (p_s.tready !== 1'b1) begin errors++; $display("FAIL post_rst_tready: got %b required 1", p_s.tready); end
    @(negedge clk);
  endtask

  task automatic test_pair_single;
    p_m.tready = 1'b1;
    p_s.tdata = in_beat(255, 255, 1, 2, 0, 0, 7, 9);
    p_s.tlast = 1'b1; p_s.tuser = 1'b1; p_s.tvalid = 1'b1;
    @(negedge clk);
    p_s.tvalid = 1'b0;
    #1;
    checks++; if (p_m.tvalid !== 1'b0) begin errors++; $display("FAIL pair_lat1: tvalid %b required 0", p_m.tvalid); end
    @(negedge clk); #1;
    checks++; if (p_m.tvalid !== 1'b1) begin errors++; $display("FAIL pair_lat2: tvalid %b required 1", p_m.tvalid); end
    checks++; if (p_m.tdata !== out_beat(510, 3, 0, 16)) begin errors++; $display("FAIL pair_data: got %h required %h", p_m.tdata, out_beat(510, 3, 0, 16)); end
    checks++; if (p_m.tlast !== 1'b1 || p_m.tuser !== 1'b1) begin errors++; $display("FAIL pair_side: got %b/%b required 1/1", p_m.tlast, p_m.tuser); end
    @(negedge clk); #1;
    checks++; if (p_m.tvalid !== 1'b0) begin errors++; $display("FAIL pair_once: tvalid %b required 0", p_m.tvalid); end
    checks++; if (p_cnt !== 32'd1) begin errors++; $display("FAIL pair_count: got %0d required 1", p_cnt); end
  endtask

  task automatic test_back_to_back;
    int unsigned in_idx, out_idx;
    logic saw_block, hold_valid;
    logic [OUT_W-1:0] hold_data;
    in_idx = 0; out_idx = 0; saw_block = 1'b0; hold_valid = 1'b0; hold_data = '0;
    for (int c = 0; c < 60 && out_idx < 10; c++) begin
      @(negedge clk);
      p_m.tready = !(c >= 3 && c <= 6);
      p_s.tvalid = (in_idx < 10);
      p_s.tdata  = bp_in(in_idx);
      p_s.tlast  = (in_idx == 9);
      p_s.tuser  = in_idx[0];
      #1;
      if (hold_valid) begin
        checks++;
        if (p_m.tvalid !== 1'b1 || p_m.tdata !== hold_data) begin
          errors++; $display("FAIL bp_hold: got %b/%h required 1/%h", p_m.tvalid, p_m.tdata, hold_data);
        end
      end
      hold_valid = p_m.tvalid && !p_m.tready;
      hold_data  = p_m.tdata;
      if (p_m.tvalid && p_m.tready) begin
        checks++;
        if (p_m.tdata !== bp_out(out_idx) || p_m.tlast !== (out_idx == 9) || p_m.tuser !== out_idx[0]) begin
          errors++; $display("FAIL bp_beat%0d: got %h/%b/%b required %h/%b/%b", out_idx, p_m.tdata,
                             p_m.tlast, p_m.tuser, bp_out(out_idx), (out_idx == 9), out_idx[0]);
        end
        out_idx++;
      end
      if (p_s.tvalid && !p_s.tready) saw_block = 1'b1;
      if (p_s.tvalid && p_s.tready) in_idx++;
    end
    @(negedge clk);
    p_s.tvalid = 1'b0;
    #1;
    checks++; if (out_idx != 10 || in_idx != 10) begin errors++; $display("FAIL bp_counts: in %0d out %0d required 10/10", in_idx, out_idx); end
    checks++; if (saw_block !== 1'b1) begin errors++; $display("FAIL bp_tready_low: got %b required 1", saw_block); end
    checks++; if (p_cnt !== 32'd11) begin errors++; $display("FAIL bp_count: got %0d required 11", p_cnt); end
    checks++; if (p_m.tvalid !== 1'b0) begin errors++; $display("FAIL bp_drain: tvalid %b required 0", p_m.tvalid); end
  endtask

  task automatic test_acc_frame;
    logic [OUT_W-1:0] exp_d [4];
    logic             exp_l [4];
    a_m.tready = 1'b1;
    mon_q.delete();
    a_send(in_beat(1, 2, 0, 0, 2, 0, 0, 0), 1'b0, 1'b0);
    a_send(in_beat(3, 4, 0, 0, 2, 0, 0, 0), 1'b0, 1'b1);
    a_send(in_beat(5, 6, 0, 0, 2, 0, 0, 0), 1'b1, 1'b0);
    a_send(in_beat(1, 1, 0, 0, 0, 0, 0, 0), 1'b1, 1'b1);
    exp_d[0] = out_beat(3, 0, 2, 0);  exp_l[0] = 1'b0;
    exp_d[1] = out_beat(10, 0, 4, 0); exp_l[1] = 1'b0;
    exp_d[2] = out_beat(21, 0, 6, 0); exp_l[2] = 1'b1;
    exp_d[3] = out_beat(2, 0, 0, 0);  exp_l[3] = 1'b1;
    wait_mon(4);
    for (int i = 0; i < 4; i++) begin
      if (i < mon_q.size()) begin
        checks++;
        if (mon_q[i].d !== exp_d[i] || mon_q[i].l !== exp_l[i] || mon_q[i].u !== 1'(i % 2)) begin
          errors++; $display("FAIL acc_frame%0d: got %h/%b/%b required %h/%b/%b", i, mon_q[i].d,
                             mon_q[i].l, mon_q[i].u, exp_d[i], exp_l[i], 1'(i % 2));
        end
      end
    end
  endtask

  task automatic test_acc_wrap;
    logic [OUT_W-1:0] exp_d [4];
    logic             exp_sat;
`ifdef AXIS_ADDER_SATURATE_EN
    exp_d[0] = out_beat(510, 0, 0, 0); exp_d[1] = out_beat(511, 0, 0, 0);
    exp_d[2] = out_beat(511, 0, 0, 0); exp_sat = 1'b1;
`else
    exp_d[0] = out_beat(510, 0, 0, 0); exp_d[1] = out_beat(508, 0, 0, 0);
    exp_d[2] = out_beat(506, 0, 0, 0); exp_sat = 1'b0;
`endif
    exp_d[3] = out_beat(2, 0, 0, 0);
    mon_q.delete();
    a_send(in_beat(255, 255, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0);
    a_send(in_beat(255, 255, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0);
    a_send(in_beat(255, 255, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0);
    wait_mon(3);
    checks++; if (a_sat !== exp_sat) begin errors++; $display("FAIL wrap_sat: got %b required %b", a_sat, exp_sat); end
    a_send(in_beat(1, 1, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0);
    wait_mon(4);
    for (int i = 0; i < 4; i++) begin
      if (i < mon_q.size()) begin
        checks++;
        if (mon_q[i].d !== exp_d[i]) begin
          errors++; $display("FAIL wrap_beat%0d: got %h required %h", i, mon_q[i].d, exp_d[i]);
        end
      end
    end
    checks++; if (a_sat !== exp_sat) begin errors++; $display("FAIL wrap_sticky: got %b required %b", a_sat, exp_sat); end
    checks++; if (a_cnt !== 32'd8) begin errors++; $display("FAIL wrap_count: got %0d required 8", a_cnt); end
  endtask

  task automatic test_reset_midframe;
    mon_q.delete();
    a_m.tready = 1'b0;
    a_send(in_beat(10, 10, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0);
    a_send(in_beat(1, 1, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0);
    @(negedge clk); #1;
    checks++; if (a_m.tvalid !== 1'b1) begin errors++; $display("FAIL mid_inflight: tvalid %b required 1", a_m.tvalid); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (a_m.tvalid !== 1'b0) begin errors++; $display("FAIL mid_tvalid: got %b required 0", a_m.tvalid); end
    checks++; if (a_cnt !== 32'd0) begin errors++; $display("FAIL mid_count: got %0d required 0", a_cnt); end
    checks++; if (a_sat !== 1'b0) begin errors++; $display("FAIL mid_sat: got %b required 0", a_sat); end
    a_m.tready = 1'b1;
    @(negedge clk);
    checks++; if (mon_q.size() != 0) begin errors++; $display("FAIL mid_partial: got %0d beats required 0", mon_q.size()); end
    a_send(in_beat(4, 4, 0, 0, 0, 0, 0, 0), 1'b1, 1'b1);
    wait_mon(1);
    if (mon_q.size() > 0) begin
      checks++;
      if (mon_q[0].d !== out_beat(8, 0, 0, 0)) begin
        errors++; $display("FAIL mid_restart: got %h required %h", mon_q[0].d, out_beat(8, 0, 0, 0));
      end
    end
  endtask

  task automatic test_random;
    beat_t exp_q[$];
    int unsigned acc [4];
    int unsigned sent, s, av, bv;
    logic took;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mon_q.delete();
    for (int i = 0; i < 4; i++) acc[i] = 0;
    sent = 0; took = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (sent == 1000 && mon_q.size() >= 1000) break;
      if (took) a_s.tvalid = 1'b0;
      took = 1'b0;
      a_m.tready = ($urandom_range(0, 3) != 0);
      if (!a_s.tvalid && sent < 1000 && $urandom_range(0, 2) != 0) begin
        a_s.tdata  = IN_W'({$urandom, $urandom});
        a_s.tlast  = ($urandom_range(0, 3) == 0);
        a_s.tuser  = 1'($urandom_range(0, 1));
        a_s.tvalid = 1'b1;
      end
      #1;
      if (a_s.tvalid && a_s.tready) begin
        beat_t e;
        e.d = '0;
        for (int i = 0; i < 4; i++) begin
          av = int'(a_s.tdata[16*i +: 8]);
          bv = int'(a_s.tdata[16*i+8 +: 8]);
          s = acc[i] + av + bv;
`ifdef AXIS_ADDER_SATURATE_EN
          if (s > 511) s = 511;
`else
          s = s % 512;
`endif
          e.d[9*i +: 9] = 9'(s);
          acc[i] = a_s.tlast ? 0 : s;
        end
        e.l = a_s.tlast;
        e.u = a_s.tuser;
        exp_q.push_back(e);
        sent++;
        took = 1'b1;
      end
    end
    a_s.tvalid = 1'b0;
    #1;
    checks++; if (mon_q.size() != 1000 || exp_q.size() != 1000) begin errors++; $display("FAIL rnd_beats: got %0d/%0d required 1000", mon_q.size(), exp_q.size()); end
    for (int i = 0; i < 1000; i++) begin
      if (i < mon_q.size() && i < exp_q.size()) begin
        checks++;
        if (mon_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL rnd_beat%0d: got %h required %h", i, mon_q[i], exp_q[i]);
        end
      end
    end
    checks++; if (a_cnt !== 32'd1000) begin errors++; $display("FAIL rnd_count: got %0d required 1000", a_cnt); end
  endtask

  initial begin
    p_s.tvalid = 1'b0; p_s.tdata = '0; p_s.tlast = 1'b0; p_s.tuser = '0; p_m.tready = 1'b0;
    a_s.tvalid = 1'b0; a_s.tdata = '0; a_s.tlast = 1'b0; a_s.tuser = '0; a_m.tready = 1'b0;
    test_reset();
    test_pair_single();
    test_back_to_back();
    test_acc_frame();
    test_acc_wrap();
    test_reset_midframe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
